// File: rtl/sb_pkg.sv
// Shared types and constants for the sideband transmit path.
package sb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } sb_tx_state_t;

  localparam int unsigned SB_PKT_64  = 64;
  localparam int unsigned SB_PKT_128 = 128;

endpackage

// File: rtl/sb_clk_gate.sv
// Latch-based integrated clock gate: enable is captured while pll_clk is low, so gclk
// can only start or stop on a whole high phase.
module sb_clk_gate (
  input  logic pll_clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Transparent while the clock is low; holds through the high phase.
  always_latch begin
    if (!pll_clk) begin
      en_lat = en;
    end
  end

  assign gclk = pll_clk & en_lat;

endmodule

// File: rtl/sb_tx_packet_engine.sv
// Sideband transmit engine: queues 64/128-bit packets in a small FIFO and serialises
// them on TXDATASB with a gated forwarded clock TXCKSB, separated by GAP_UI idle UI.
module sb_tx_packet_engine
  import sb_pkg::*;
#(
  parameter int unsigned MAX_PKT_W  = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_UI     = 32,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                          pll_clk,
  input  logic                          rst_n,
  input  logic [MAX_PKT_W-1:0]          data_in,
  input  logic                          pkt_len,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          tx_en,
  output logic                          TXCKSB,
  output logic                          TXDATASB,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(MAX_PKT_W);
  localparam int unsigned GapW = 6;

  // FIFO state
  logic [MAX_PKT_W:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     level_q;
  logic                out_of_reset_q;
  logic                push, pop, len_in;
  logic [MAX_PKT_W:0]  head;

  // Serialiser state
  sb_tx_state_t        state_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic [GapW-1:0]     gap_cnt_q;
  logic [MAX_PKT_W-1:0] pkt_q;
  logic                len_q;
  logic                txd_q;
  logic                busy_q;
  logic [CntW-1:0]     last_idx, bit_idx;
  logic                cur_bit, can_start, gclk;

  // Long packets only exist in the 128-bit build.
  assign len_in = (MAX_PKT_W == SB_PKT_128) ? pkt_len : 1'b0;
  assign ready  = out_of_reset_q && (level_q != LvlW'(FIFO_DEPTH));
  assign push   = valid && ready;
  assign head   = mem_q[rd_ptr_q];

  assign can_start = (state_q == StIdle) || ((state_q == StGap) && (gap_cnt_q == '0));
  assign pop       = can_start && (level_q != '0) && tx_en;

  assign last_idx = len_q ? CntW'(MAX_PKT_W - 1) : CntW'(SB_PKT_64 - 1);
  assign bit_idx  = LSB_FIRST ? (last_idx - bit_cnt_q) : bit_cnt_q;
  assign cur_bit  = pkt_q[bit_idx];

  // Payload storage; flushed logically by the pointer reset, so no reset needed here.
  always_ff @(posedge pll_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {len_in, data_in};
    end
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      out_of_reset_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Packet FSM; TXDATASB lags the SHIFT state by one cycle so it lines up with the gated clock.
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      pkt_q     <= '0;
      len_q     <= 1'b0;
      txd_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      txd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q   <= StShift;
            busy_q    <= 1'b1;
            pkt_q     <= head[MAX_PKT_W-1:0];
            len_q     <= head[MAX_PKT_W];
            bit_cnt_q <= head[MAX_PKT_W] ? CntW'(MAX_PKT_W - 1) : CntW'(SB_PKT_64 - 1);
          end
        end
        StShift: begin
          txd_q <= cur_bit;
          if (bit_cnt_q == '0) begin
            state_q   <= StGap;
            gap_cnt_q <= GapW'(GAP_UI - 1);
          end else begin
            bit_cnt_q <= bit_cnt_q - CntW'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
          end else if (pop) begin
            // Back-to-back: the next packet starts without an extra idle cycle.
            state_q   <= StShift;
            pkt_q     <= head[MAX_PKT_W-1:0];
            len_q     <= head[MAX_PKT_W];
            bit_cnt_q <= head[MAX_PKT_W] ? CntW'(MAX_PKT_W - 1) : CntW'(SB_PKT_64 - 1);
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gate enable is latched in the low phase before each data UI, giving one pulse per bit.
  sb_clk_gate u_clk_gate (
    .pll_clk (pll_clk),
    .en      (state_q == StShift),
    .gclk    (gclk)
  );

  // rst_n kills an in-progress high phase immediately.
  assign TXCKSB     = gclk & rst_n;
  assign TXDATASB   = txd_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_sb_tx_packet_engine.sv
// Self-checking bench for sb_tx_packet_engine (default parameters).
module tb_sb_tx_packet_engine;

  localparam int GAP   = 32;
  localparam int DEPTH = 4;

  logic         pll_clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic         pkt_len;
  logic         valid;
  logic         ready;
  logic         tx_en;
  logic         TXCKSB;
  logic         TXDATASB;
  logic         busy;
  logic [2:0]   fifo_level;

  sb_tx_packet_engine dut (
    .pll_clk    (pll_clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .pkt_len    (pkt_len),
    .valid      (valid),
    .ready      (ready),
    .tx_en      (tx_en),
    .TXCKSB     (TXCKSB),
    .TXDATASB   (TXDATASB),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  int checks = 0;
  int errors = 0;

  // Receiver-side monitor, one sample per UI just after the rising edge.
  bit rx_bits[$];
  bit exp_bits[$];
  int gaps[$];
  int pulses    = 0;
  int low_run   = 0;
  int data_viol = 0;
  bit seen_pulse = 0;

  always begin
    @(posedge pll_clk);
    #1;
    if (TXCKSB === 1'b1) begin
      rx_bits.push_back(TXDATASB);
      pulses++;
      if (seen_pulse && low_run > 0) gaps.push_back(low_run);
      seen_pulse = 1;
      low_run    = 0;
    end else begin
      low_run++;
      if (TXDATASB !== 1'b0) data_viol++;
    end
  end

  typedef struct {
    logic         valid;
    logic         len;
    logic [127:0] data;
    logic         exp_ready;
    logic [2:0]   exp_level;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add_exp(input logic len, input logic [127:0] d);
    int n = len ? 128 : 64;
    for (int i = 0; i < n; i++) exp_bits.push_back(d[i]);
  endfunction

  task automatic clear_mon();
    rx_bits.delete();
    exp_bits.delete();
    gaps.delete();
    pulses     = 0;
    low_run    = 0;
    data_viol  = 0;
    seen_pulse = 0;
  endtask

  task automatic tick();
    @(posedge pll_clk);
    #1;
  endtask

  // Let everything queued go out, then compare the received stream with the model.
  task automatic drain(input string name, input bit exact_gap);
    int n    = 0;
    int bad  = 0;
    int mism = 0;
    int m;
    valid = 1'b0;
    tx_en = 1'b1;
    while ((fifo_level != 0 || busy) && n < 20000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 128'(n < 20000), 128'd1);
    repeat (2) tick();
    chk({name, "_len"}, rx_bits.size(), exp_bits.size());
    m = (rx_bits.size() < exp_bits.size()) ? rx_bits.size() : exp_bits.size();
    for (int i = 0; i < m; i++) if (rx_bits[i] != exp_bits[i]) mism++;
    chk({name, "_bits"}, mism, 0);
    foreach (gaps[i]) begin
      if (exact_gap ? (gaps[i] != GAP) : (gaps[i] < GAP)) bad++;
    end
    chk({name, "_gap"}, bad, 0);
    chk({name, "_datalow"}, data_viol, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int m_level;
    int first, last, bfall, n;
    logic [2:0] prev;
    int seq[$];

    rst_n   = 1'b0;
    valid   = 1'b0;
    tx_en   = 1'b0;
    pkt_len = 1'b0;
    data_in = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ck", TXCKSB, 0);
    chk("rst_data", TXDATASB, 0);
    chk("rst_level", fifo_level, 0);
    #2 rst_n = 1'b1;
    #1 chk("ready_pre_edge", ready, 0);
    tick();
    chk("ready_first_edge", ready, 1);
    clear_mon();

    // Fill with tx_en low: 5th push dropped, no clock
    for (int i = 0; i < 6; i++) begin
      vecs[i].valid     = (i < 5);
      vecs[i].len       = i[0];
      vecs[i].data      = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].exp_level = (i < 4) ? 3'(i + 1) : 3'd4;
      vecs[i].exp_ready = (i < 3);
    end
    m_level = 0;
    for (int i = 0; i < 6; i++) begin
      valid   = vecs[i].valid;
      pkt_len = vecs[i].len;
      data_in = vecs[i].data;
      if (vecs[i].valid && m_level < DEPTH) begin
        add_exp(vecs[i].len, vecs[i].data);
        m_level++;
      end
      tick();
      chk($sformatf("fill%0d_level", i), fifo_level, vecs[i].exp_level);
      chk($sformatf("fill%0d_ready", i), ready, vecs[i].exp_ready);
      chk($sformatf("fill%0d_busy", i), busy, 0);
      chk($sformatf("fill%0d_ck", i), TXCKSB, 0);
    end
    valid = 1'b0;
    drain("fill", 1'b1);
    chk("fill_ngaps", gaps.size(), 3);

    // Single 64-bit packet: latency, length, gap, busy fall
    clear_mon();
    tx_en   = 1'b1;
    valid   = 1'b1;
    pkt_len = 1'b0;
    data_in = {64'h0, 64'hA5A5_0000_FFFF_1234};
    add_exp(1'b0, data_in);
    tick();
    valid = 1'b0;
    chk("single_level", fifo_level, 1);
    first = -1; last = -1; bfall = -1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (TXCKSB) begin
        if (first < 0) first = k;
        last = k;
      end
      if (!busy && bfall < 0) bfall = k;
    end
    chk("single_first_pulse", first, 2);
    chk("single_last_pulse", last, 65);
    chk("single_busy_fall", bfall, 65 + GAP);
    chk("single_pulses", pulses, 64);
    drain("single", 1'b1);

    // Two 128-bit packets back to back
    clear_mon();
    tx_en = 1'b0;
    seq.delete();
    for (int i = 0; i < 2; i++) begin
      valid   = 1'b1;
      pkt_len = 1'b1;
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      add_exp(1'b1, data_in);
      tick();
      seq.push_back(int'(fifo_level));
    end
    valid = 1'b0;
    tx_en = 1'b1;
    prev  = fifo_level;
    n     = 0;
    while ((fifo_level != 0 || busy) && n < 2000) begin
      tick();
      n++;
      if (fifo_level != prev) begin
        seq.push_back(int'(fifo_level));
        prev = fifo_level;
      end
    end
    chk("two_seq_len", seq.size(), 4);
    if (seq.size() == 4) chk("two_seq", {seq[0], seq[1], seq[2], seq[3]}, {32'd1, 32'd2, 32'd1, 32'd0});
    drain("two", 1'b1);
    chk("two_pulses", pulses, 256);
    chk("two_ngaps", gaps.size(), 1);

    // tx_en dropped mid-packet with two more queued
    clear_mon();
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid   = 1'b1;
      pkt_len = 1'b0;
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      add_exp(1'b0, data_in);
      tick();
    end
    valid = 1'b0;
    tx_en = 1'b1;
    n = 0;
    while (pulses < 10 && n < 200) begin
      tick();
      n++;
    end
    tx_en = 1'b0;
    chk("drop_reached", 128'(n < 200), 1);
    repeat (150) tick();
    chk("drop_pulses", pulses, 64);
    chk("drop_level", fifo_level, 2);
    chk("drop_busy", busy, 0);
    drain("drop", 1'b0);

    // Reset in the middle of a 128-bit packet
    clear_mon();
    tx_en   = 1'b1;
    valid   = 1'b1;
    pkt_len = 1'b1;
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    pkt_len = 1'b0;
    data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    valid = 1'b0;
    n = 0;
    while (pulses < 40 && n < 200) begin
      tick();
      n++;
    end
    chk("rstmid_reached", 128'(n < 200), 1);
    chk("rstmid_ck_high", TXCKSB, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_ck", TXCKSB, 0);
    chk("rstmid_data", TXDATASB, 0);
    chk("rstmid_level", fifo_level, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", ready, 0);
    repeat (2) @(posedge pll_clk);
    #3 rst_n = 1'b1;
    clear_mon();
    repeat (300) tick();
    chk("rstmid_after_pulses", pulses, 0);
    chk("rstmid_after_ready", ready, 1);
    chk("rstmid_after_level", fifo_level, 0);

    // Randomised traffic against the stream model
    clear_mon();
    for (int c = 0; c < 2000; c++) begin
      valid   = ($urandom_range(0, 2) == 0);
      pkt_len = 1'($urandom_range(0, 1));
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tx_en   = ($urandom_range(0, 7) != 0);
      if (valid && ready) add_exp(pkt_len, data_in);
      tick();
    end
    drain("rand", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_tx_packet_engine.md
SB_TX_PACKET_ENGINE -- requirements
Module: sb_tx_packet_engine

Interface
REQ-001 SHALL have parameter MAX_PKT_W, default 128, maximum packet width in bits; legal values 64 or 128.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of queued packets; power of two, 2..16.
REQ-003 SHALL have parameter GAP_UI, default 32, number of idle UI between packets; 1..63.
REQ-004 SHALL have parameter LSB_FIRST, default 1, 1 = bit 0 sent first, 0 = MSB of the active length sent first.
REQ-005 SHALL have port pll_clk, input, 1, the single block clock; one UI equals one pll_clk period.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_in, input, MAX_PKT_W, packet payload.
REQ-008 SHALL have port pkt_len, input, 1, 0 = 64-bit packet using data_in[63:0], 1 = 128-bit packet; tied to 0 when MAX_PKT_W=64.
REQ-009 SHALL have port valid, input, 1, producer offers data_in/pkt_len.
REQ-010 SHALL have port ready, output, 1, high when the FIFO is not full.
REQ-011 SHALL have port tx_en, input, 1, permits starting new packets.
REQ-012 SHALL have port TXCKSB, output, 1, gated sideband clock.
REQ-013 SHALL have port TXDATASB, output, 1, serial sideband data.
REQ-014 SHALL have port busy, output, 1, high when FSM is not IDLE.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-016 SHALL push {pkt_len, data_in} on a rising pll_clk edge where valid && ready; ready = (fifo_level != FIFO_DEPTH), combinational from registered state only.
REQ-017 SHALL ignore valid when ready is low; no overwrite, no error flag.
REQ-018 SHALL update fifo_level by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-019 SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-020 IDLE -> SHIFT when FIFO non-empty and tx_en high: pop head, load shift register, load bit counter with 63 or 127.
REQ-021 In SHIFT, TXDATASB SHALL present one bit per pll_clk cycle in order per LSB_FIRST, with the TXCKSB gate enabled for exactly 64 or 128 UI.
REQ-022 SHIFT -> GAP when the bit counter reaches 0 at the end of the last UI.
REQ-023 In GAP, TXDATASB SHALL be 0 and TXCKSB SHALL be held low for exactly GAP_UI cycles.
REQ-024 GAP -> SHIFT when FIFO non-empty and tx_en high, with no extra cycle; otherwise GAP -> IDLE.
REQ-025 tx_en falling during SHIFT SHALL NOT truncate the packet; the current packet and its gap complete, then the FSM holds in IDLE.
REQ-026 In IDLE, TXCKSB SHALL be held low and TXDATASB SHALL be 0.
REQ-027 Latency: a push at edge N into an empty FIFO with FSM in IDLE and tx_en high SHALL produce the first bit on TXDATASB and the first TXCKSB pulse in the cycle following edge N+2.
REQ-028 TXDATASB SHALL be registered on the pll_clk rising edge; TXCKSB SHALL be pll_clk gated glitch-free, so the receiver samples on the TXCKSB falling edge (mid-UI).
REQ-029 busy SHALL be high in SHIFT and GAP.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, fifo_level=0, ready=0 while asserted, TXDATASB=0, TXCKSB=0, busy=0, flushing all queued packets including a packet in flight.
REQ-031 After rst_n deasserts, ready SHALL rise on the first pll_clk edge.

Structure
REQ-032 The shared package sb_pkg SHALL hold the FSM state enum (sb_tx_state_t) and the packet length constants SB_PKT_64=64 and SB_PKT_128=128.
REQ-033 Glitch-free clock gating SHALL be one sub-module, sb_clk_gate (latch-based ICG with ports pll_clk, en, gclk); all other logic SHALL be flat.

Verification
REQ-034 Single 64-bit packet 0xA5A5_0000_FFFF_1234 with LSB_FIRST=1: 64 TXCKSB pulses, serial bits equal the payload LSB first, then 32 UI with data low and no clock, busy falls.
REQ-035 Two back-to-back 128-bit pushes: exactly GAP_UI=32 clock-free UI between packets, 256 total pulses, fifo_level sequence 1,2,1,0.
REQ-036 Five pushes with tx_en=0: ready falls after the 4th push, the 5th is dropped, fifo_level=4, TXCKSB stays low.
REQ-037 rst_n asserted at UI 40 of a 128-bit packet: TXCKSB and TXDATASB go to 0 asynchronously, fifo_level=0, no further pulses after release.
REQ-038 tx_en dropped at UI 10 of a packet with 2 queued: the current packet completes in full (64 pulses), then IDLE holds with fifo_level=2.
